// File: rtl/div_radix2.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in the EX stage.
// One quotient bit per cycle; LO=quotient, HI=remainder; stalls the pipeline while busy.
module div_radix2 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             annul_i,
  output logic             stall_o,
  output logic             ready_o,
  output logic [WIDTH-1:0] quot_o,
  output logic [WIDTH-1:0] rem_o,
  output logic [1:0]       dbg_state_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [CW-1:0]    r_count;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic             r_sign_q;
  logic             r_sign_r;
  logic [WIDTH-1:0] r_quot_o;
  logic [WIDTH-1:0] r_rem_o;

  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_b_zero;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_dvs_ext;
  logic             w_ge;
  logic [WIDTH:0]   w_rem_nx;
  logic [WIDTH-1:0] w_quo_nx;
  logic [WIDTH-1:0] w_rem_lo;
  logic [WIDTH-1:0] w_quot_fin;
  logic [WIDTH-1:0] w_rem_fin;

  // Operand conditioning: magnitudes only for signed divides.
  assign w_a_neg  = signed_i & a_i[WIDTH-1];
  assign w_b_neg  = signed_i & b_i[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -a_i : a_i;
  assign w_b_mag  = w_b_neg ? -b_i : b_i;
  assign w_b_zero = (b_i == '0);
  assign w_accept = (r_state == S_IDLE) & start_i & ~annul_i;
  assign w_last   = (r_count == CW'(WIDTH - 1));

  // One restoring step; the extra remainder bit keeps the compare from overflowing.
  assign w_rem_sh   = (r_rem << 1) | {{WIDTH{1'b0}}, r_quo[WIDTH-1]};
  assign w_dvs_ext  = {1'b0, r_dvs};
  assign w_ge       = (w_rem_sh >= w_dvs_ext);
  assign w_rem_nx   = w_ge ? (w_rem_sh - w_dvs_ext) : w_rem_sh;
  assign w_quo_nx   = {r_quo[WIDTH-2:0], w_ge};
  assign w_rem_lo   = w_rem_nx[WIDTH-1:0];
  assign w_quot_fin = r_sign_q ? -w_quo_nx : w_quo_nx;
  assign w_rem_fin  = r_sign_r ? -w_rem_lo : w_rem_lo;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_next_state = w_b_zero ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        if (w_last) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
    // Flush wins over everything, including a start in IDLE.
    if (annul_i) begin
      w_next_state = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_quot_o <= '0;
      r_rem_o  <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_count <= '0;
            if (w_b_zero) begin
              r_quot_o <= '1;
              r_rem_o  <= a_i;
            end else begin
              r_rem    <= '0;
              r_quo    <= w_a_mag;
              r_dvs    <= w_b_mag;
              r_sign_q <= signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
              r_sign_r <= signed_i & a_i[WIDTH-1];
            end
          end
        end
        S_BUSY: begin
          if (!annul_i) begin
            r_rem   <= w_rem_nx;
            r_quo   <= w_quo_nx;
            r_count <= r_count + 1'b1;
            if (w_last) begin
              r_quot_o <= w_quot_fin;
              r_rem_o  <= w_rem_fin;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign stall_o     = w_accept | (r_state == S_BUSY);
  assign ready_o     = (r_state == S_DONE) & ~annul_i;
  assign quot_o      = r_quot_o;
  assign rem_o       = r_rem_o;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_div_radix2.sv
// Bench for div_radix2: directed spec cases, random divides against an arithmetic model,
// annul/reset/back-to-back/held-start scenarios.
module tb_div_radix2;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_i = 1'b0;
  logic         signed_i = 1'b0;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic         annul_i = 1'b0;
  logic         stall_o;
  logic         ready_o;
  logic [W-1:0] quot_o;
  logic [W-1:0] rem_o;
  logic [1:0]   dbg_state_o;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [W-1:0] exp_q[$];

  div_radix2 #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .signed_i(signed_i),
    .a_i(a_i), .b_i(b_i), .annul_i(annul_i), .stall_o(stall_o),
    .ready_o(ready_o), .quot_o(quot_o), .rem_o(rem_o), .dbg_state_o(dbg_state_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain 64-bit arithmetic, truncating division, remainder follows dividend.
  function automatic void model(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r);
    longint sa, sb, lq, lr;
    if (b == '0) begin
      q = '1;
      r = a;
    end else begin
      if (sgn) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = longint'(a);
        sb = longint'(b);
      end
      lq = sa / sb;
      lr = sa % sb;
      q = lq[W-1:0];
      r = lr[W-1:0];
    end
  endfunction

  // Issue one divide from IDLE and wait (bounded) for the ready pulse.
  task automatic run_div(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                         output bit iss_stall, output int lat, output int busy_stall,
                         output bit rdy_stall, output logic [W-1:0] q, output logic [W-1:0] r,
                         output int rdy_cyc);
    @(negedge clk);
    signed_i = sgn; a_i = a; b_i = b; start_i = 1'b1;
    #1 iss_stall = stall_o;
    lat = -1; busy_stall = 0; rdy_stall = 1'b1; q = 'x; r = 'x; rdy_cyc = -1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (ready_o) begin
        lat = k; q = quot_o; r = rem_o; rdy_stall = stall_o; rdy_cyc = cyc;
        break;
      end
      if (stall_o) busy_stall++;
      if (k == 1) begin
        start_i = 1'b0;
        a_i = $urandom; b_i = $urandom; signed_i = ~sgn;
      end
    end
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall_o); end
    total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", ready_o); end
    total++; if (quot_o !== '0) begin bad++; $display("FAIL reset_quot got=%h exp=0", quot_o); end
    total++; if (rem_o !== '0) begin bad++; $display("FAIL reset_rem got=%h exp=0", rem_o); end
    total++; if (dbg_state_o !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", dbg_state_o); end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    bit           ts [7] = '{0, 1, 1, 0, 1, 0, 1};
    logic [W-1:0] ta [7] = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFFF, 32'h8000_0000, 32'd5, 32'hFFFF_FFF9};
    logic [W-1:0] tb [7] = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0};
    logic [W-1:0] tq [7] = '{32'd14, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [W-1:0] tr [7] = '{32'd2, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd5, 32'hFFFF_FFF9};
    bit iss, rs; int lat, bs, rc; logic [W-1:0] q, r;
    int exp_lat, exp_bs;
    for (int i = 0; i < 7; i++) begin
      run_div(ts[i], ta[i], tb[i], iss, lat, bs, rs, q, r, rc);
      exp_lat = (tb[i] == '0) ? 1 : W + 1;
      exp_bs  = (tb[i] == '0) ? 0 : W;
      total++; if (q !== tq[i]) begin bad++; $display("FAIL dir%0d_quot got=%h exp=%h", i, q, tq[i]); end
      total++; if (r !== tr[i]) begin bad++; $display("FAIL dir%0d_rem got=%h exp=%h", i, r, tr[i]); end
      total++; if (lat !== exp_lat) begin bad++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, exp_lat); end
      total++; if (bs !== exp_bs) begin bad++; $display("FAIL dir%0d_busy_stall got=%0d exp=%0d", i, bs, exp_bs); end
      total++; if (iss !== 1'b1) begin bad++; $display("FAIL dir%0d_issue_stall got=%b exp=1", i, iss); end
      total++; if (rs !== 1'b0) begin bad++; $display("FAIL dir%0d_ready_stall got=%b exp=0", i, rs); end
    end
  endtask

  task automatic test_random();
    bit iss, rs, sgn; int lat, bs, rc; logic [W-1:0] a, b, q, r, eq, er;
    for (int i = 0; i < 40; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 5))
        0: b = '0;
        1: b = W'($urandom_range(1, 15));
        2: begin a = 32'h8000_0000; b = $urandom_range(0, 1) ? 32'hFFFF_FFFF : b; end
        3: b = b >> $urandom_range(8, 28);
        default: ;
      endcase
      model(sgn, a, b, eq, er);
      exp_q.push_back(eq);
      exp_q.push_back(er);
      run_div(sgn, a, b, iss, lat, bs, rs, q, r, rc);
      eq = exp_q.pop_front();
      er = exp_q.pop_front();
      total++; if (q !== eq) begin bad++; $display("FAIL rnd%0d_quot s=%0d a=%h b=%h got=%h exp=%h", i, sgn, a, b, q, eq); end
      total++; if (r !== er) begin bad++; $display("FAIL rnd%0d_rem s=%0d a=%h b=%h got=%h exp=%h", i, sgn, a, b, r, er); end
      total++; if (lat !== ((b == '0) ? 1 : W + 1)) begin bad++; $display("FAIL rnd%0d_latency got=%0d", i, lat); end
    end
  endtask

  task automatic test_annul();
    bit iss, rs; int lat, bs, rc, pulses;
    logic [W-1:0] q, r;
    run_div(1'b0, 32'd20, 32'd3, iss, lat, bs, rs, q, r, rc);
    @(negedge clk);
    signed_i = 1'b0; a_i = 32'd1000; b_i = 32'd9; start_i = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0;
    total++; if (dbg_state_o !== 2'd0) begin bad++; $display("FAIL annul_state got=%0d exp=0", dbg_state_o); end
    total++; if (quot_o !== 32'd6) begin bad++; $display("FAIL annul_quot_kept got=%h exp=6", quot_o); end
    total++; if (rem_o !== 32'd2) begin bad++; $display("FAIL annul_rem_kept got=%h exp=2", rem_o); end
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      if (ready_o) pulses++;
      @(negedge clk);
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL annul_no_ready got=%0d exp=0", pulses); end
    run_div(1'b0, 32'd50, 32'd5, iss, lat, bs, rs, q, r, rc);
    total++; if (q !== 32'd10) begin bad++; $display("FAIL annul_restart_quot got=%h exp=a", q); end
    total++; if (r !== 32'd0) begin bad++; $display("FAIL annul_restart_rem got=%h exp=0", r); end
    // Flush landing on the DONE cycle hides the pulse.
    @(negedge clk);
    signed_i = 1'b0; a_i = 32'd5; b_i = 32'd0; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; annul_i = 1'b1;
    #1;
    total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL annul_done_ready got=%b exp=0", ready_o); end
    @(negedge clk);
    annul_i = 1'b0;
    total++; if (dbg_state_o !== 2'd0) begin bad++; $display("FAIL annul_done_state got=%0d exp=0", dbg_state_o); end
  endtask

  task automatic test_back_to_back();
    bit iss, rs; int lat, bs, rc1, rc2;
    logic [W-1:0] q1, r1, q2, r2;
    run_div(1'b0, 32'd20, 32'd3, iss, lat, bs, rs, q1, r1, rc1);
    run_div(1'b0, 32'd9, 32'd4, iss, lat, bs, rs, q2, r2, rc2);
    total++; if (q1 !== 32'd6) begin bad++; $display("FAIL b2b_quot1 got=%h exp=6", q1); end
    total++; if (r1 !== 32'd2) begin bad++; $display("FAIL b2b_rem1 got=%h exp=2", r1); end
    total++; if (q2 !== 32'd2) begin bad++; $display("FAIL b2b_quot2 got=%h exp=2", q2); end
    total++; if (r2 !== 32'd1) begin bad++; $display("FAIL b2b_rem2 got=%h exp=1", r2); end
    total++; if (rc2 - rc1 !== W + 2) begin bad++; $display("FAIL b2b_spacing got=%0d exp=%0d", rc2 - rc1, W + 2); end
  endtask

  task automatic test_rst_mid();
    int pulses;
    @(negedge clk);
    signed_i = 1'b0; a_i = 32'd77; b_i = 32'd5; start_i = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    total++; if (quot_o !== '0) begin bad++; $display("FAIL rstmid_quot got=%h exp=0", quot_o); end
    total++; if (rem_o !== '0) begin bad++; $display("FAIL rstmid_rem got=%h exp=0", rem_o); end
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL rstmid_stall got=%b exp=0", stall_o); end
    total++; if (dbg_state_o !== 2'd0) begin bad++; $display("FAIL rstmid_state got=%0d exp=0", dbg_state_o); end
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ready_o) pulses++;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL rstmid_no_ready got=%0d exp=0", pulses); end
  endtask

  task automatic test_start_held();
    int pulses, lat;
    logic [W-1:0] q, r;
    @(negedge clk);
    signed_i = 1'b0; a_i = 32'd12; b_i = 32'd5; start_i = 1'b1;
    pulses = 0; lat = -1; q = 'x; r = 'x;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (ready_o) begin pulses++; lat = k; q = quot_o; r = rem_o; break; end
    end
    @(negedge clk);
    total++; if (dbg_state_o !== 2'd0) begin bad++; $display("FAIL held_state_after_done got=%0d exp=0", dbg_state_o); end
    start_i = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ready_o) pulses++;
    end
    total++; if (pulses !== 1) begin bad++; $display("FAIL held_pulses got=%0d exp=1", pulses); end
    total++; if (lat !== W + 1) begin bad++; $display("FAIL held_latency got=%0d exp=%0d", lat, W + 1); end
    total++; if (q !== 32'd2 || r !== 32'd2) begin bad++; $display("FAIL held_result got=%h/%h exp=2/2", q, r); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_annul();
    test_back_to_back();
    test_rst_mid();
    test_start_held();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
